calc_port_responder: RTL and testbench

- Responder end of one calc1 request port: accepts the two-cycle command/operand protocol and returns a one-cycle response code with result data.
- Used as a standalone single-port calculator, and as the golden responder model behind port-level benches.
- Four instances (one per port) form a simplified calc1 core.

---
 rtl/calc_port_responder.sv | 150 +++++++++++++++
 tb/tb_calc_port_responder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/calc_port_responder.sv
// Responder for one calc1 request port: two-cycle command/operand capture, fixed-latency execute, one-cycle response.
// Optional macro CALC_BUSY_ERR_EN: commands arriving while busy poison the in-flight operation (resp 11).
module calc_port_responder #(
  parameter int unsigned EXEC_CYCLES = 2,
  parameter int unsigned DATA_W      = 32
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [3:0]        req_cmd_in,
  input  logic [DATA_W-1:0] req_data_in,
  output logic [1:0]        out_resp,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OP2  = 2'd1,
    S_EXEC = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [3:0] CMD_ADD = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_SHL = 4'b0101;
  localparam logic [3:0] CMD_SHR = 4'b0110;

  localparam logic [1:0] RESP_OK    = 2'b01;
  localparam logic [1:0] RESP_INERR = 2'b10;
  localparam logic [1:0] RESP_INTERR = 2'b11;

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_t            state_q;
  logic [3:0]        cmd_q;
  logic [DATA_W-1:0] op1_q;
  logic [DATA_W-1:0] op2_q;
  logic [3:0]        cnt_q;

  logic [DATA_W:0]   sum;
  logic [4:0]        shamt;
  logic [1:0]        res_resp_d;
  logic [DATA_W-1:0] res_data_d;
  logic              cmd_nz;
  logic              coll_hit;

  assign cmd_nz      = (req_cmd_in != 4'b0000);
  assign dbg_state_o = state_q;

`ifdef CALC_BUSY_ERR_EN
  logic coll_q;

  // Sticky until the poisoned response has been presented.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      coll_q <= 1'b0;
    end else if (state_q == S_RESP) begin
      coll_q <= 1'b0;
    end else if ((state_q == S_OP2 || state_q == S_EXEC) && cmd_nz) begin
      coll_q <= 1'b1;
    end
  end

  // A collision on the final EXEC edge still counts.
  assign coll_hit = coll_q | cmd_nz;
`else
  assign coll_hit = 1'b0;
`endif

  always_comb begin
    sum        = {1'b0, op1_q} + {1'b0, op2_q};
    shamt      = op2_q[4:0];
    res_resp_d = RESP_INERR;
    res_data_d = '0;
    case (cmd_q)
      CMD_ADD: begin
        if (!sum[DATA_W]) begin
          res_resp_d = RESP_OK;
          res_data_d = sum[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (op2_q <= op1_q) begin
          res_resp_d = RESP_OK;
          res_data_d = op1_q - op2_q;
        end
      end
      CMD_SHL: begin
        res_resp_d = RESP_OK;
        res_data_d = op1_q << shamt;
      end
      CMD_SHR: begin
        res_resp_d = RESP_OK;
        res_data_d = op1_q >> shamt;
      end
      default: begin
        res_resp_d = RESP_INERR;
        res_data_d = '0;
      end
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      cnt_q    <= '0;
      out_resp <= 2'b00;
      out_data <= '0;
      busy     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_RESP: begin
          out_resp <= 2'b00;
          out_data <= '0;
          if (cmd_nz) begin
            cmd_q   <= req_cmd_in;
            op1_q   <= req_data_in;
            busy    <= 1'b1;
            state_q <= S_OP2;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_OP2: begin
          op2_q   <= req_data_in;
          cnt_q   <= CNT_LOAD;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (cnt_q == 4'd0) begin
            out_resp <= coll_hit ? RESP_INTERR : res_resp_d;
            out_data <= coll_hit ? '0 : res_data_d;
            busy     <= 1'b0;
            state_q  <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_port_responder.sv
// Directed bench for calc_port_responder: driver tasks push expected {cycle, resp, data} entries,
// a negedge monitor pops and compares them against whatever the DUT presents.
module tb_calc_port_responder;

  localparam int EXEC = 2;
  localparam int W    = 32;
  localparam int EW   = 32 + 2 + W;

  localparam logic [3:0] ADD = 4'b0001;
  localparam logic [3:0] SUB = 4'b0010;
  localparam logic [3:0] SHL = 4'b0101;
  localparam logic [3:0] SHR = 4'b0110;

  logic         c_clk = 1'b0;
  logic         reset;
  logic [3:0]   req_cmd_in;
  logic [W-1:0] req_data_in;
  logic [1:0]   out_resp;
  logic [W-1:0] out_data;
  logic         busy;
  logic [1:0]   dbg_state_o;

  int unsigned   cyc = 0;
  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_pass = 0;
  bit            mon_en = 1'b0;

  calc_port_responder #(.EXEC_CYCLES(EXEC), .DATA_W(W)) dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (req_cmd_in),
    .req_data_in (req_data_in),
    .out_resp    (out_resp),
    .out_data    (out_data),
    .busy        (busy),
    .dbg_state_o (dbg_state_o)
  );

  // Clock and reset
  always #5 c_clk = ~c_clk;
  always @(posedge c_clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
  endtask

  // Scoreboard monitor
  always @(negedge c_clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0][EW-1 -: 32] == cyc) begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("resp_code", W'(out_resp), W'(e[W+1 -: 2]));
        check("resp_data", out_data, e[W-1:0]);
        check("busy_in_resp", W'(busy), 0);
      end else if (out_resp != 2'b00) begin
        check("unexpected_resp", W'(out_resp), 0);
      end else begin
        check("idle_data", out_data, 0);
      end
    end
  end

  // Driver tasks
  task automatic idle_cycles(input int k);
    repeat (k) begin
      @(negedge c_clk);
      req_cmd_in  = 4'b0000;
      req_data_in = '0;
    end
  endtask

  task automatic issue(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit expect_resp, input logic [1:0] er, input logic [W-1:0] ed);
    @(negedge c_clk);
    req_cmd_in  = cmd;
    req_data_in = a;
    if (expect_resp) exp_q.push_back({32'(cyc + 2 + EXEC), er, ed});
    @(negedge c_clk);
    req_cmd_in  = 4'b0000;
    req_data_in = b;
    check("busy_after_accept", W'(busy), 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) idle_cycles(1);
    idle_cycles(2);
  endtask

  initial begin
    reset       = 1'b1;
    req_cmd_in  = 4'b0000;
    req_data_in = '0;
    repeat (2) @(posedge c_clk);
    @(negedge c_clk);
    check("rst_resp", W'(out_resp), 0);
    check("rst_data", out_data, 0);
    check("rst_busy", W'(busy), 0);
    check("rst_state", W'(dbg_state_o), 0);
    reset  = 1'b0;
    mon_en = 1'b1;
    idle_cycles(2);

    issue(ADD, 32'h8000_2345, 32'h0001_0000, 1, 2'b01, 32'h8001_2345); drain();
    issue(ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1, 2'b10, 32'h0);         drain();
    issue(SUB, 32'd5, 32'd7, 1, 2'b10, 32'h0);                          drain();
    issue(SUB, 32'd7, 32'd7, 1, 2'b01, 32'h0);                          drain();
    issue(SUB, 32'd9, 32'd4, 1, 2'b01, 32'd5);                          drain();
    issue(SHL, 32'h0000_2000, 32'h0000_0001, 1, 2'b01, 32'h0000_4000); drain();
    issue(SHR, 32'h0000_2000, 32'h0000_0021, 1, 2'b01, 32'h0000_1000); drain();
    issue(4'b0011, 32'd1, 32'd1, 1, 2'b10, 32'h0);                      drain();

    // Back-to-back: second command lands on the RESP-exit edge.
    issue(ADD, 32'd1, 32'd2, 1, 2'b01, 32'd3);
    idle_cycles(2);
    issue(ADD, 32'h10, 32'h20, 1, 2'b01, 32'h30);
    drain();

    // Reset while in EXEC: operation must vanish.
    issue(ADD, 32'd5, 32'd6, 0, 2'b00, 32'h0);
    idle_cycles(1);
    reset = 1'b1;
    @(negedge c_clk);
    check("midrst_resp", W'(out_resp), 0);
    check("midrst_data", out_data, 0);
    check("midrst_busy", W'(busy), 0);
    check("midrst_state", W'(dbg_state_o), 0);
    reset = 1'b0;
    idle_cycles(6);

    // Sub arriving during EXEC of an Add.
`ifdef CALC_BUSY_ERR_EN
    issue(ADD, 32'h100, 32'h23, 1, 2'b11, 32'h0);
`else
    issue(ADD, 32'h100, 32'h23, 1, 2'b01, 32'h123);
`endif
    @(negedge c_clk);
    req_cmd_in  = SUB;
    req_data_in = 32'd9;
    idle_cycles(1);
    drain();
    idle_cycles(4);

    check("queue_empty", W'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
